// File: rtl/alu_pkg.sv
// Shared definitions for the iterative multiply/divide stage: operation
// encodings, FSM state encoding and the default datapath width.
package alu_pkg;

   // Default operand/result width; one radix-2 step per bit.
   localparam int WIDTH_DEF = 16;

   // Multi-cycle ALU operation encodings, as driven on the op port.
   typedef enum logic [1:0] {
      OP_MUL_LO = 2'b00,
      OP_MUL_HI = 2'b01,
      OP_DIV    = 2'b10,
      OP_MOD    = 2'b11
   } op_t;

   // Sequencer states. The encoding is visible on the top-level debug port.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Divide and modulo share the restoring-division datapath.
   function automatic logic is_div_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of either unsigned shift-add multiply or unsigned
// restoring division. Purely combinational; the caller owns the registers.
//
// Working register layout (2*WIDTH bits):
//   multiply : full product register. It is seeded with {0, multiplier}.
//              Each step adds the multiplicand into the high half when the
//              current LSB is set, then shifts the whole thing right by one.
//   divide   : {remainder[WIDTH-1:0], dividend/quotient[WIDTH-1:0]}. It is
//              seeded with {0, dividend}. Each step shifts the next dividend
//              bit into a WIDTH+1 bit partial remainder and trial-subtracts
//              the divisor. The quotient bit enters at the LSB.
module muldiv_step
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0] mul_sum;
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] rem_diff;
   logic           q_bit;

   // Single-iteration datapath for both modes. The mode mux sits at the end.
   always_comb begin
      mul_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                  + (acc_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      rem_shift = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, opnd};
      // No borrow means the divisor fits, so the quotient bit is 1.
      q_bit     = ~rem_diff[WIDTH];
      if (is_div) begin
         // When the divisor does not fit, rem_shift < divisor < 2**WIDTH.
         // Its top bit is therefore zero and is safe to drop.
         acc_out = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                    acc_in[WIDTH-2:0], q_bit};
      end else begin
         acc_out = {mul_sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply/divide stage feeding the accumulator D input.
// Takes operand A (accumulator Q feedback) and operand B (datapath). It runs
// one radix-2 step per clock and reports via a start/busy/done handshake.
//
// Handshake: start is sampled on each rising clk edge while in IDLE or DONE.
// An accepted start latches op/a/b. busy is high for exactly the WIDTH RUN
// cycles. done is high for the single DONE cycle. result/err/ovf change only
// on the edge entering DONE and hold otherwise, so they stay valid from done
// onward. start during RUN is dropped, not queued. A start in the DONE cycle
// begins the next op with no idle gap.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int               WIDTH     = WIDTH_DEF,
   parameter logic [WIDTH-1:0] DIV0_QUOT = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err,
   output logic             ovf,
   output state_t           dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state_q;
   state_t             state_d;
   op_t                op_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_step;
   logic [CW-1:0]      cnt_q;

   logic               accept;
   logic               div0;
   logic               last_step;
   logic [WIDTH-1:0]   fin_result;
   logic               fin_ovf;

   assign last_step = (cnt_q == CW'(WIDTH - 1));
   assign dbg_state = state_q;

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div  (is_div_op(op_q)),
      .acc_in  (acc_q),
      .opnd    (opnd_q),
      .acc_out (acc_step)
   );

   // State register; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic, start acceptance and handshake outputs.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      div0    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            if (start) begin
               accept = 1'b1;
               // Divide by zero needs no iterations; report it at once.
               if (is_div_op(op) && (b == '0)) begin
                  div0    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_step) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Latch operands on accept; advance the working register during RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_MUL_LO;
         opnd_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else if (accept) begin
         op_q  <= op_t'(op);
         cnt_q <= '0;
         if (is_div_op(op)) begin
            // Divisor is the fixed operand; dividend shifts out of acc.
            opnd_q <= b;
            acc_q  <= {{WIDTH{1'b0}}, a};
         end else begin
            // Multiplicand is the fixed operand; multiplier shifts out of acc.
            opnd_q <= a;
            acc_q  <= {{WIDTH{1'b0}}, b};
         end
      end else if (state_q == S_RUN) begin
         acc_q <= acc_step;
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Select the finished value from the last iteration's output.
   always_comb begin
      fin_result = '0;
      fin_ovf    = 1'b0;
      case (op_q)
         OP_MUL_LO: begin
            fin_result = acc_step[WIDTH-1:0];
            fin_ovf    = |acc_step[2*WIDTH-1:WIDTH];
         end
         OP_MUL_HI: fin_result = acc_step[2*WIDTH-1:WIDTH];
         OP_DIV:    fin_result = acc_step[WIDTH-1:0];
         OP_MOD:    fin_result = acc_step[2*WIDTH-1:WIDTH];
         default:   fin_result = '0;
      endcase
   end

   // Output registers load only on the edge entering DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         err    <= 1'b0;
         ovf    <= 1'b0;
      end else if (div0) begin
         result <= (op == OP_DIV) ? DIV0_QUOT : a;
         err    <= 1'b1;
         ovf    <= 1'b0;
      end else if ((state_q == S_RUN) && last_step) begin
         result <= fin_result;
         err    <= 1'b0;
         ovf    <= fin_ovf;
      end
   end

endmodule
